// File: rtl/mem_stage_if.sv
// EX-to-MEM pipeline handshake bundle: valid/allowin plus the instruction payload.
// The EX stage drives it as master and the MEM stage consumes it as slave.
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [5:0]  es_load_op;
    logic [1:0]  es_addr_low;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic [31:0] es_result;
    logic [31:0] es_pc;

    modport master (
        output es_to_ms_valid,
        output es_load_op,
        output es_addr_low,
        output es_gr_we,
        output es_dest,
        output es_result,
        output es_pc,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid,
        input  es_load_op,
        input  es_addr_low,
        input  es_gr_we,
        input  es_dest,
        input  es_result,
        input  es_pc,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, extracts/extends load data and
// buffers the SRAM word so a load stalled by WB keeps its first-cycle data.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  es,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    input  logic        ms_flush,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic        ms_gr_we,
    output logic [4:0]  ms_dest,
    output logic [31:0] ms_final_result,
    output logic        ms_fwd_we,
    output logic [4:0]  ms_fwd_dest,
    output logic [31:0] ms_fwd_data
);

    // load_op bit positions: {ld_b, ld_h, ld_w, ld_bu, ld_hu, ll_w}
    localparam int OP_LD_B  = 5;
    localparam int OP_LD_H  = 4;
    localparam int OP_LD_W  = 3;
    localparam int OP_LD_BU = 2;
    localparam int OP_LD_HU = 1;
    localparam int OP_LL_W  = 0;

    logic        ms_valid_reg;
    logic        ms_valid_next;
    logic        buf_valid_reg;
    logic        buf_valid_next;
    logic [31:0] rdata_buf_reg;
    logic [5:0]  load_op_reg;
    logic [1:0]  addr_low_reg;
    logic        gr_we_reg;
    logic [4:0]  dest_reg;
    logic [31:0] result_reg;
    logic [31:0] pc_reg;

    logic        ms_ready_go;
    logic        ms_allowin;
    logic        ws_fire;
    logic        es_enter;
    logic        is_load;
    logic        capture_en;
    logic [31:0] rd_word;
    logic [7:0]  word_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    assign ms_ready_go   = 1'b1;
    assign ms_allowin    = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign es.ms_allowin = ms_allowin;
    assign ws_fire       = ms_valid_reg && ms_ready_go && ws_allowin;
    assign es_enter      = es.es_to_ms_valid && ms_allowin && !ms_flush;
    assign is_load       = |load_op_reg;
    // Capture only while WB is stalling; a firing load consumes the live word.
    assign capture_en    = ms_valid_reg && is_load && !buf_valid_reg && !ws_allowin && !ms_flush;

    always_comb begin
        ms_valid_next = ms_valid_reg;
        if (ms_flush) begin
            ms_valid_next = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_next = es.es_to_ms_valid;
        end
    end

    always_comb begin
        buf_valid_next = buf_valid_reg;
        if (ms_flush || ws_fire || es_enter) begin
            buf_valid_next = 1'b0;
        end else if (capture_en) begin
            buf_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_reg  <= 1'b0;
            buf_valid_reg <= 1'b0;
            rdata_buf_reg <= 32'd0;
        end else begin
            ms_valid_reg  <= ms_valid_next;
            buf_valid_reg <= buf_valid_next;
            if (capture_en) begin
                rdata_buf_reg <= data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_op_reg  <= 6'd0;
            addr_low_reg <= 2'd0;
            gr_we_reg    <= 1'b0;
            dest_reg     <= 5'd0;
            result_reg   <= 32'd0;
            pc_reg       <= 32'd0;
        end else if (es_enter) begin
            load_op_reg  <= es.es_load_op;
            addr_low_reg <= es.es_addr_low;
            gr_we_reg    <= es.es_gr_we;
            dest_reg     <= es.es_dest;
            result_reg   <= es.es_result;
            pc_reg       <= es.es_pc;
        end
    end

    assign rd_word = buf_valid_reg ? rdata_buf_reg : data_sram_rdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign word_byte[gi] = rd_word[8*gi +: 8];
    end

    assign sel_byte = word_byte[addr_low_reg];
    assign sel_half = addr_low_reg[1] ? rd_word[31:16] : rd_word[15:0];

    // Overlapping opcode bits resolve word > half > half-unsigned > byte > byte-unsigned.
    always_comb begin
        load_data = 32'd0;
        if (load_op_reg[OP_LD_W] || load_op_reg[OP_LL_W]) begin
            load_data = rd_word;
        end else if (load_op_reg[OP_LD_H]) begin
            load_data = {{16{sel_half[15]}}, sel_half};
        end else if (load_op_reg[OP_LD_HU]) begin
            load_data = {16'd0, sel_half};
        end else if (load_op_reg[OP_LD_B]) begin
            load_data = {{24{sel_byte[7]}}, sel_byte};
        end else if (load_op_reg[OP_LD_BU]) begin
            load_data = {24'd0, sel_byte};
        end
    end

    assign ms_to_ws_valid  = ms_valid_reg;
    assign ms_pc           = pc_reg;
    assign ms_dest         = dest_reg;
    assign ms_gr_we        = gr_we_reg && (dest_reg != 5'd0);
    assign ms_final_result = is_load ? load_data : result_reg;
    assign ms_fwd_we       = ms_valid_reg && ms_gr_we;
    assign ms_fwd_dest     = dest_reg;
    assign ms_fwd_data     = ms_final_result;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 es_to_ms_valid  in  1  EX stage presents a valid instruction.
REQ-005 es_load_op  in  6  one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu, ll_w}; 0 = not a load.
REQ-006 es_addr_low  in  2  low two bits of the effective address driven to data SRAM in EX.
REQ-007 es_gr_we  in  1  instruction writes a GPR.
REQ-008 es_dest  in  5  destination GPR index.
REQ-009 es_result  in  32  EX result, used when not a load.
REQ-010 es_pc  in  32  instruction PC.
REQ-011 data_sram_rdata  in  32  SRAM read data, valid only in the cycle after the EX-stage request.
REQ-012 ws_allowin  in  1  WB stage can accept.
REQ-013 ms_flush  in  1  discard the MEM-stage instruction.
REQ-014 ms_allowin  out  1  MEM can accept from EX this cycle.
REQ-015 ms_to_ws_valid  out  1  valid instruction offered to WB.
REQ-016 ms_pc  out  32  PC of held instruction.
REQ-017 ms_gr_we  out  1  GPR write enable to WB.
REQ-018 ms_dest  out  5  destination GPR to WB.
REQ-019 ms_final_result  out  32  load data or EX result.
REQ-020 ms_fwd_we / ms_fwd_dest / ms_fwd_data  out  1/5/32  bypass to ID: ms_valid & ms_gr_we, ms_dest, ms_final_result.

Function
REQ-021 ms_ready_go SHALL be constant 1; ms_allowin = !ms_valid | ws_allowin (combinational).
REQ-022 ms_valid SHALL update each edge: ms_flush -> 0 (highest priority); else if ms_allowin -> es_to_ms_valid; else hold.
REQ-023 Payload registers (load_op, addr_low, gr_we, dest, result, pc) SHALL load only when es_to_ms_valid & ms_allowin & !ms_flush; otherwise hold.
REQ-024 ms_to_ws_valid SHALL equal ms_valid; handshake fires when ms_to_ws_valid & ws_allowin.
REQ-025 Read-data buffer: buf_valid and 32-bit rdata_buf; when ms_valid & is_load & !buf_valid & !ws_allowin, capture data_sram_rdata and set buf_valid.
REQ-026 buf_valid SHALL clear on handshake fire, on ms_flush, and when a new instruction enters; capture and clear are never simultaneous (capture requires !ws_allowin).
REQ-027 Selected read word = buf_valid ? rdata_buf : data_sram_rdata; a load stalled N cycles SHALL return data from its first MEM cycle.
REQ-028 ld_b / ld_bu: byte = word[8*addr_low +: 8]; sign- / zero-extend to 32.
REQ-029 ld_h / ld_hu: half = addr_low[1] ? word[31:16] : word[15:0]; addr_low[0] ignored (no misalignment detection here); sign- / zero-extend.
REQ-030 ld_w / ll_w: full word, addr_low ignored.
REQ-031 Multiple load_op bits set SHALL resolve by priority ld_w/ll_w > ld_h > ld_hu > ld_b > ld_bu.
REQ-032 ms_final_result = (|load_op) ? extracted data : result.
REQ-033 ms_gr_we = gr_we & (dest != 0); ms_fwd_we = ms_valid & ms_gr_we.
REQ-034 Latency: instruction accepted at edge k is offered to WB in cycle k+1; throughput one per cycle when ws_allowin stays high.

Reset
REQ-035 While resetn = 0 at an edge: ms_valid, buf_valid, all payload registers and rdata_buf SHALL become 0; hence every output is 0 except ms_allowin = 1.
REQ-036 Reset mid-stall SHALL drop the held instruction and buffered data; no output from it appears after reset.

Verification
REQ-037 ld_b, addr_low=3, rdata=0x80xx_xxxx, ws_allowin=1 -> next cycle ms_final_result=0xFFFF_FF80, ms_to_ws_valid=1.
REQ-038 ld_hu, addr_low=2, rdata=0x8001_1234 -> 0x0000_8001; ld_h same -> 0xFFFF_8001.
REQ-039 ld_w in MEM, ws_allowin=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after the first cycle -> result stays the first-cycle word; ms_allowin=0 throughout; fires when ws_allowin=1.
REQ-040 non-load, gr_we=1, dest=0, result=0x1234 -> ms_gr_we=0, ms_fwd_we=0, ms_final_result=0x1234.
REQ-041 ms_flush together with es_to_ms_valid=1 -> next cycle ms_valid=0, buf_valid=0, payload unchanged.
REQ-042 resetn=0 during stalled load -> next cycle all outputs 0, ms_allowin=1.
